// File: rtl/booth_mul_seq_ctrl.sv
// Sequential radix-2 Booth signed multiplier controller: one add/sub + arithmetic
// shift per clock for WIDTH clocks, then a registered 2*WIDTH-bit product and a done pulse.
module booth_mul_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int              CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   INC  = CW'(1);
    localparam logic [WIDTH:0]  ONE  = (WIDTH + 1)'(1);

    // One-hot encoding so each status output is a single state flop.
    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_RUN  = 3'b010,
        S_DONE = 3'b100
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [WIDTH:0]         r_a;
    logic [WIDTH-1:0]       r_q;
    logic                   r_q_1;
    logic [WIDTH:0]         r_mx;
    logic [CW-1:0]          r_count;
    logic [2*WIDTH-1:0]     r_product;

    logic                   w_accept;
    logic                   w_step;
    logic                   w_last;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_a_next;
    logic [WIDTH-1:0]       w_q_next;
    logic                   w_q1_next;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_step   = (r_state == S_RUN);
    assign w_last   = w_step && (r_count == LAST);

    // NOTE: state is held in flops updated with <= only; all decode is combinational.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: default assigned first so no path through the case infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Booth recoding on {Q[0], Q_1}; subtraction as add of the inverted operand plus one.
    always_comb begin
        w_sum = r_a;
        case ({r_q[0], r_q_1})
            2'b01:   w_sum = r_a + r_mx;
            2'b10:   w_sum = r_a + ~r_mx + ONE;
            default: w_sum = r_a;
        endcase
    end

    assign w_a_next  = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign w_q_next  = {w_sum[0], r_q[WIDTH-1:1]};
    assign w_q1_next = r_q[0];

    // NOTE: every datapath register is cleared by reset so an aborted run leaves no residue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_q       <= '0;
            r_q_1     <= 1'b0;
            r_mx      <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            if (w_accept) begin
                r_a     <= '0;
                r_q     <= multiplier;
                r_q_1   <= 1'b0;
                r_mx    <= {multiplicand[WIDTH-1], multiplicand};
                r_count <= '0;
            end else if (w_step) begin
                r_a     <= w_a_next;
                r_q     <= w_q_next;
                r_q_1   <= w_q1_next;
                r_count <= r_count + INC;
            end
            if (w_last) begin
                r_product <= {w_a_next[WIDTH-1:0], w_q_next};
            end
        end
    end

    assign ready   = (r_state == S_IDLE);
    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign product = r_product;

    a_state_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(r_state));
    a_done_pulse:   assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule
